// File: rtl/stream_mux.sv
// stream_mux: registered N-channel, W-bit stream multiplexer with valid/ready
// handshakes on every input and on the output.
//
// Selection modes:
//   mode=0 : fixed select, channel index taken from sel (sel >= N never grants)
//   mode=1 : round-robin across valid channels, search starts at rr_ptr
//
// A single output register gives 1-cycle latency at full throughput. A new beat
// is loaded whenever the register is empty or being consumed on the same edge.
//
// Optional feature (macro STREAM_MUX_LAST_EN): packet lock. Adds in_last and
// out_last. A beat accepted with in_last=0 locks arbitration to its channel
// until that channel's last beat is accepted.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index for mode=0
//   in_valid   per-channel valid (bit i = channel i)
//   in_ready   per-channel ready, at most one bit high
//   in_data    flattened data, channel i at [i*W +: W]
//   in_last    per-channel end-of-packet (STREAM_MUX_LAST_EN only)
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   out_data   registered data
//   out_ch     channel that produced out_data
//   out_last   registered end-of-packet (STREAM_MUX_LAST_EN only)

module stream_mux #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
`ifdef STREAM_MUX_LAST_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch
);

  logic [SW-1:0] rr_ptr;
  logic          load;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic          xfer;
  logic          last_beat;

`ifdef STREAM_MUX_LAST_EN
  logic          locked;
  logic [SW-1:0] lock_ch;
  assign last_beat = in_last[grant_idx];
`else
  assign last_beat = 1'b1;
`endif

  // Register is free when empty or drained on this same edge.
  assign load = !out_valid || out_ready;

  // Grant only ever points at a valid channel, so load && grant_vld is a transfer.
  always_comb begin
    int c;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
`ifdef STREAM_MUX_LAST_EN
    if (locked) begin
      grant_vld = in_valid[lock_ch];
      grant_idx = lock_ch;
    end else
`endif
    if (!mode) begin
      if (int'(sel) < N) begin
        grant_vld = in_valid[sel];
        grant_idx = sel;
      end
    end else begin
      // Walk offsets from the far end down so the offset closest to rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        c = int'(rr_ptr) + k;
        if (c >= N) c = c - N;
        if (in_valid[c]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(c);
        end
      end
    end
  end

  assign xfer = load && grant_vld;

  always_comb begin
    in_ready = '0;
    if (!rst && xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant_idx)*W +: W];
        out_ch    <= grant_idx;
      end else if (load) begin
        out_valid <= 1'b0;
      end
      // Pointer moves only in round-robin, and only at packet boundaries.
      if (xfer && mode && last_beat)
        rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef STREAM_MUX_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      out_last <= last_beat;
      locked   <= !last_beat;
      if (!last_beat) lock_ch <= grant_idx;
    end
  end
`endif

endmodule
